multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control unit for the multicycle ARM datapath. It sequences every instruction through a Moore state machine and drives the datapath muxes and write enables. It also generates the extender select ImmSrc (00 imm8, 01 imm12, 10 branch imm24) and the ALU function. It holds the NZCV flag register and evaluates condition codes to gate all architectural writes.

Parameters:
FLAG_RST, 4'b0000, reset value of the {N,Z,C,V} flag register

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
Rd  in  4  Instr[15:12]
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0=PC, 1=ALUResult register
RegSrc  out  2  register-file read-address selects
ALUSrcA  out  1  0=RD1 register, 1=PC
ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  extender format select
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN. State register updates on posedge clk.
- Reset (sync): state<=FETCH, Flags<=FLAG_RST, CondLat<=0. While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. First fetch occurs in the cycle after reset deasserts.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 ->MEMADR; Op=00 & Funct[5]=0 ->EXECR; Op=00 & Funct[5]=1 ->EXECI; Op=10 ->BRANCH; Op=11 ->UNKNOWN.
  - MEMADR: Funct[0]=1 ->MEMREAD, else ->MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECR/EXECI->ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN ->FETCH.
- Internal Moore signals, all 0 unless listed:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: nothing.
- Decode (combinational from Op):
  - ImmSrc=Op, except Op=11 gives 00.
  - RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
- ALUOp=1: Funct[4:1] 0100->00, 0010->01, 0000->10, 1100->11; any other cmd ->00 with FlagW=00.
- ALUOp=0: ALUControl=00, FlagW=00.
- FlagW[1] (NZ) = Funct[0] & ALUOp. FlagW[0] (CV) = Funct[0] & ALUOp & (ALUControl is 00 or 01).
- PCS = (Rd==4'hF & RegW) | Branch.
- CondEx from current Flags and Cond:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE ~(~Z&(N==V)); E AL 1; F 0.
  - CondLat<=CondEx at the clock edge leaving DECODE.
  - CondLat holds for the rest of the instruction, so a flag update in EXEC* does not affect its own writeback.
- Gating:
  - PCWrite = NextPC | (PCS & CondLat).
  - RegWrite = RegW & CondLat.
  - MemWrite = MemW & CondLat.
  - NZ<=ALUFlags[3:2] when FlagW[1] & CondLat; CV<=ALUFlags[1:0] when FlagW[0] & CondLat. Flag writes occur only in EXECR/EXECI.
- Latency per instruction, in cycles: LDR 5; STR 4; data-processing 4; branch 3; unknown 3.

Test Plan:
- Reset held 2 cycles, then released with an ADD-reg instruction (Op=00, Funct=001000, Cond=E) -> FETCH, DECODE, EXECR, ALUWB. IRWrite=1 only in FETCH. RegWrite=1 only in ALUWB. ImmSrc=00, ALUControl=00 in EXECR.
- SUBS-imm (Funct=100101) with ALUFlags=0100 in EXECI -> Flags=0100 after EXECI. Next instruction: Cond=0 (EQ) gives RegWrite=1 in ALUWB; Cond=1 (NE) gives RegWrite=0.
- LDR (Op=01, Funct[0]=1, Cond=E) -> 5-state sequence. AdrSrc=1 in MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB. ImmSrc=01, RegSrc=10.
- STR with Flags Z=0 and Cond=0 -> MEMWRITE visited with MemWrite=0.
- Branch (Op=10, Cond=E) -> PCWrite=1 in FETCH and in BRANCH, ImmSrc=10, RegSrc=01. ADD to Rd=15 -> PCWrite=1 in ALUWB.
- Op=11 -> UNKNOWN then FETCH with no writes. Reset asserted in MEMREAD -> next state FETCH, Flags=0000, no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control unit for a multicycle ARM datapath
//
// Sequences each instruction through FETCH/DECODE/... states and drives the
// datapath selects and write enables. Holds the {N,Z,C,V} flag register and
// gates every architectural write with the condition latched during DECODE.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   Cond        Instr[31:28] condition field
//   Op          Instr[27:26] instruction class
//   Funct       Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   Rd          Instr[15:12] destination register
//   ALUFlags    {N,Z,C,V} from the ALU in the current cycle
//   PCWrite     PC register enable
//   MemWrite    data memory write enable
//   RegWrite    register file write enable
//   IRWrite     instruction register enable
//   AdrSrc      memory address select (0=PC, 1=ALUResult register)
//   RegSrc      register-file read-address selects
//   ALUSrcA     ALU A select (0=RD1 register, 1=PC)
//   ALUSrcB     ALU B select (00=RD2 register, 01=ExtImm, 10=constant 4)
//   ResultSrc   result select (00=ALUOut, 01=Data, 10=ALUResult)
//   ImmSrc      extender format (00 imm8, 01 imm12, 10 imm24)
//   ALUControl  ALU function (00 ADD, 01 SUB, 10 AND, 11 ORR)

module multicycle_ctrl #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condlat_q, condlat_d;

  // Moore-level controls before condition gating
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       alu_op;
  logic       ir_w;

  logic [1:0] flag_w;
  logic       cond_ex;
  logic       pcs;

  // State, flags and latched condition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAG_RST;
      condlat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      condlat_q <= condlat_d;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d   = state_q;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    ir_w      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcB = 2'b00;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Instruction-field decode
  always_comb begin
    ImmSrc = (Op == 2'b11) ? 2'b00 : Op;
    RegSrc = {Op == 2'b01, Op == 2'b10};
  end

  // ALU decoder; unsupported commands execute as ADD and never touch flags
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      unique case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flag_w = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; flag_w = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; flag_w = {Funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; flag_w = {Funct[0], 1'b0};     end
        default: begin ALUControl = 2'b00; flag_w = 2'b00;                end
      endcase
    end
  end

  // Condition evaluation against the architectural flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    unique case (Cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~(c & ~z);
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = ~z & (n == v);
      4'hD:    cond_ex = ~(~z & (n == v));
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // The condition is captured once per instruction so a flag update in
  // EXEC* cannot change the outcome of its own writeback.
  always_comb begin
    condlat_d = (state_q == S_DECODE) ? cond_ex : condlat_q;
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & condlat_q) flags_d[3:2] = ALUFlags[3:2];
    if (flag_w[0] & condlat_q) flags_d[1:0] = ALUFlags[1:0];
  end

  // Writes to R15 and branches both redirect the PC
  assign pcs = ((Rd == 4'hF) & reg_w) | branch;

  // Write enables are held low while reset is asserted
  always_comb begin
    PCWrite  = ~reset & (next_pc | (pcs & condlat_q));
    RegWrite = ~reset & reg_w & condlat_q;
    MemWrite = ~reset & mem_w & condlat_q;
    IRWrite  = ~reset & ir_w;
  end

endmodule
